// File: rtl/uart_tx_arb_if.sv
// Bundle between the byte producers, the TX arbiter and the uart_tx serializer.
// master = producers plus serializer side, slave = the arbiter.
interface uart_tx_arb_if #(
    parameter int NUM_REQ = 4
);
    localparam int OW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           tx_data;
    logic                 tx_n;
    logic                 tx_ready;
    logic [OW-1:0]        owner;
    logic                 locked;
    logic                 busy;

    modport master (
        output req_valid, req_data, req_last, tx_ready,
        input  req_ready, tx_data, tx_n, owner, locked, busy
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_ready,
        output req_ready, tx_data, tx_n, owner, locked, busy
    );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one uart_tx serializer among NUM_REQ byte producers,
// with packet locking. Optional lock timeout: define UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arb #(
    parameter int NUM_REQ      = 4,
    parameter int LOCK_TIMEOUT = 50000
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_tx_arb_if.slave  bus
);
    localparam int OW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, SEND, HOLD} state_t;

    state_t          state_q, state_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_n_q, tx_n_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   rr_q, rr_d;
    logic            last_q, last_d;
    logic [NUM_REQ-1:0] req_ready_c;
    logic [OW-1:0]   grant;
    logic [OW-1:0]   sel;
    logic            capture;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
    logic [15:0] cnt_q, cnt_d;
`endif

    // First valid requester scanning upward from rr+1, wrapping.
    always_comb begin : p_grant
        int idx;
        logic found;
        grant = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(rr_q) + k) % NUM_REQ;
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                grant = OW'(idx);
            end
        end
    end

    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
    always_comb begin : p_next
        state_d     = state_q;
        tx_data_d   = tx_data_q;
        tx_n_d      = tx_n_q;
        owner_d     = owner_q;
        rr_d        = rr_q;
        last_d      = last_q;
        req_ready_c = '0;
        capture     = 1'b0;
        sel         = owner_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (|bus.req_valid) begin
                    capture = 1'b1;
                    sel     = grant;
                end
            end
            SEND: begin
                if (bus.tx_ready) begin
                    tx_n_d = 1'b0;
                    if (last_q) begin
                        rr_d    = owner_q;
                        state_d = IDLE;
                    end else begin
                        state_d = HOLD;
`ifdef UART_TX_ARB_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
            end
            HOLD: begin
                if (bus.req_valid[owner_q]) begin
                    capture = 1'b1;
                    sel     = owner_q;
                end
`ifdef UART_TX_ARB_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = IDLE;
                    rr_d    = owner_q;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        if (capture) begin
            req_ready_c[sel] = 1'b1;
            tx_data_d        = bus.req_data[8*int'(sel) +: 8];
            tx_n_d           = 1'b1;
            owner_d          = sel;
            last_d           = bus.req_last[sel];
            state_d          = SEND;
`ifdef UART_TX_ARB_TIMEOUT_EN
            cnt_d            = '0;
`endif
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tx_data_q <= 8'h00;
            tx_n_q    <= 1'b0;
            owner_q   <= '0;
            rr_q      <= OW'(NUM_REQ - 1);
            last_q    <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
            tx_n_q    <= tx_n_d;
            owner_q   <= owner_d;
            rr_q      <= rr_d;
            last_q    <= last_d;
`ifdef UART_TX_ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_n      = tx_n_q;
    assign bus.owner     = owner_q;
    assign bus.locked    = (state_q == HOLD);
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: single byte, round-robin, packet lock,
// lock timeout (or permanent lock without the macro) and asynchronous reset.
module tb_uart_tx_arb;
    localparam int NUM_REQ  = 4;
    localparam int RESP_DLY = 1;

    logic clk;
    logic rst_n;
    logic resp_en;
    int   total = 0;
    int   bad   = 0;

    uart_tx_arb_if #(.NUM_REQ(NUM_REQ)) ifc ();

    uart_tx_arb #(.NUM_REQ(NUM_REQ), .LOCK_TIMEOUT(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // uart_tx stand-in: a one-cycle tx_ready pulse RESP_DLY cycles after tx_n rises.
    initial begin : p_resp
        int wcnt;
        wcnt = 0;
        ifc.tx_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (ifc.tx_ready) begin
                ifc.tx_ready = 1'b0;
            end else if (resp_en && ifc.tx_n) begin
                if (wcnt == RESP_DLY) begin
                    ifc.tx_ready = 1'b1;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int idx_of(input logic [NUM_REQ-1:0] v);
        for (int i = 0; i < NUM_REQ; i++)
            if (v[i]) return i;
        return -1;
    endfunction

    // Polls until some req_ready is high; counts tx_ready pulses and cycles on the way.
    task automatic wait_grant(output int idx, output int pulses, output int waited);
        idx = -1;
        pulses = 0;
        waited = 0;
        while (waited < 60) begin
            if (ifc.tx_ready) pulses++;
            if (|ifc.req_ready) begin
                idx = idx_of(ifc.req_ready);
                return;
            end
            step();
            waited++;
        end
        check("grant_wait_timeout", 32'd1, 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ifc.req_valid = '0;
        ifc.req_last  = '0;
        ifc.req_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin : p_main
        int idx, pulses, waited, seen;
        resp_en = 1'b1;
        rst_n = 1'b0;
        ifc.req_valid = '0;
        ifc.req_last  = '0;
        ifc.req_data  = '0;
        #2;
        // Reset values.
        check("rst_tx_n", 32'(ifc.tx_n), 32'd0);
        check("rst_tx_data", 32'(ifc.tx_data), 32'h00);
        check("rst_owner", 32'(ifc.owner), 32'd0);
        check("rst_locked", 32'(ifc.locked), 32'd0);
        check("rst_busy", 32'(ifc.busy), 32'd0);
        check("rst_req_ready", 32'(ifc.req_ready), 32'd0);
        do_reset();

        // Single byte from requester 0.
        step();
        ifc.req_valid = 4'b0001;
        ifc.req_data  = 32'h0000_0055;
        ifc.req_last  = 4'b0001;
        #1;
        check("single_ready", 32'(ifc.req_ready), 32'b0001);
        step();
        ifc.req_valid = '0;
        check("single_tx_n", 32'(ifc.tx_n), 32'd1);
        check("single_tx_data", 32'(ifc.tx_data), 32'h55);
        check("single_busy", 32'(ifc.busy), 32'd1);
        check("single_ready_pulse", 32'(ifc.req_ready), 32'd0);
        seen = 0;
        for (int i = 0; i < 20 && !ifc.tx_ready; i++) begin
            check("single_tx_n_held", 32'(ifc.tx_n), 32'd1);
            step();
            seen = i + 1;
        end
        check("single_txr_seen", 32'(ifc.tx_ready), 32'd1);
        check("single_tx_n_drop", 32'(ifc.tx_n), 32'd0);
        check("single_busy_drop", 32'(ifc.busy), 32'd0);

        // Round-robin among four always-valid single-byte requesters.
        do_reset();
        ifc.req_data  = 32'h1312_1110;
        ifc.req_last  = 4'b1111;
        ifc.req_valid = 4'b1111;
        #1;
        for (int n = 0; n < 5; n++) begin
            wait_grant(idx, pulses, waited);
            check("rr_grant", 32'(idx), 32'(n % 4));
            if (n > 0) check("rr_one_txr", 32'(pulses), 32'd1);
            step();
            check("rr_owner", 32'(ifc.owner), 32'(n % 4));
            check("rr_tx_data", 32'(ifc.tx_data), 32'(8'h10 + n % 4));
        end
        ifc.req_valid = '0;

        // Packet lock: requester 2 sends A0 A1 A2 while requester 1 waits.
        do_reset();
        ifc.req_data  = 32'h00A0_1100;
        ifc.req_last  = 4'b0010;
        ifc.req_valid = 4'b0100;
        #1;
        wait_grant(idx, pulses, waited);
        check("pkt_first", 32'(idx), 32'd2);
        step();
        ifc.req_valid = 4'b0110;
        ifc.req_data  = 32'h00A1_1100;
        wait_grant(idx, pulses, waited);
        check("pkt_second", 32'(idx), 32'd2);
        check("pkt_locked1", 32'(ifc.locked), 32'd1);
        step();
        ifc.req_data = 32'h00A2_1100;
        ifc.req_last = 4'b0110;
        wait_grant(idx, pulses, waited);
        check("pkt_third", 32'(idx), 32'd2);
        check("pkt_locked2", 32'(ifc.locked), 32'd1);
        step();
        check("pkt_tx_a2", 32'(ifc.tx_data), 32'hA2);
        ifc.req_valid = 4'b0010;
        wait_grant(idx, pulses, waited);
        check("pkt_then_req1", 32'(idx), 32'd1);
        check("pkt_a2_txr", 32'(pulses), 32'd1);
        check("pkt_unlocked", 32'(ifc.locked), 32'd0);
        step();
        check("pkt_tx_11", 32'(ifc.tx_data), 32'h11);
        ifc.req_valid = '0;

        // Lock held by requester 3 with valid dropped; requester 0 waits.
        do_reset();
        ifc.req_data  = 32'h3300_0001;
        ifc.req_last  = 4'b0001;
        ifc.req_valid = 4'b1000;
        #1;
        wait_grant(idx, pulses, waited);
        check("to_first", 32'(idx), 32'd3);
        step();
        ifc.req_valid = 4'b0001;
`ifdef UART_TX_ARB_TIMEOUT_EN
        wait_grant(idx, pulses, waited);
        check("to_grant0", 32'(idx), 32'd0);
        check("to_cycles", 32'(waited), 32'd10);
        check("to_unlocked", 32'(ifc.locked), 32'd0);
`else
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (|ifc.req_ready) seen++;
            step();
        end
        check("nolock_release", 32'(seen), 32'd0);
        check("still_locked", 32'(ifc.locked), 32'd1);
        check("still_owner3", 32'(ifc.owner), 32'd3);
`endif

        // Asynchronous reset while requester 3 holds the lock and tx_n is high.
        do_reset();
        ifc.req_data  = 32'h3000_0001;
        ifc.req_last  = 4'b0001;
        ifc.req_valid = 4'b1000;
        #1;
        wait_grant(idx, pulses, waited);
        check("ar_first", 32'(idx), 32'd3);
        step();
        ifc.req_data  = 32'h3100_0001;
        ifc.req_valid = 4'b1001;
        wait_grant(idx, pulses, waited);
        check("ar_hold_grant", 32'(idx), 32'd3);
        check("ar_locked", 32'(ifc.locked), 32'd1);
        resp_en = 1'b0;
        step();
        step();
        check("ar_tx_n_high", 32'(ifc.tx_n), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_tx_n", 32'(ifc.tx_n), 32'd0);
        check("ar_busy", 32'(ifc.busy), 32'd0);
        check("ar_locked0", 32'(ifc.locked), 32'd0);
        check("ar_owner0", 32'(ifc.owner), 32'd0);
        step();
        rst_n = 1'b1;
        resp_en = 1'b1;
        #1;
        wait_grant(idx, pulses, waited);
        check("ar_req0_first", 32'(idx), 32'd0);
        ifc.req_valid = '0;
        repeat (5) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
